fft_input_framer: RTL

Upstream feeder for the 16-point FFT core. Accepts a valid/ready stream of 4-bit complex samples and packs them into 16-sample frames in a ping-pong buffer. For each frame it pulses the core's active-high reset, then drives one sample per clock for 16 consecutive cycles. It launches the next frame only after the core reports FFT_Done, or after a timeout.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_pingpong_ram.sv | 97 +++++++++
 rtl/fft_input_framer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT input framer and its ping-pong storage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_pkg;

  // Default frame geometry; the framer's parameters default to these.
  localparam int N      = 16;
  localparam int DATA_W = 4;
  localparam int IDX_W  = $clog2(N);

  // One complex sample; 'real' is a reserved word, hence re/im.
  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } sample_t;

  // Read-side sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_STREAM    = 2'd2,
    ST_WAIT_DONE = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame store with per-bank full flags and write/read index tracking.
// Latency: write lands at the accepting edge; read data is combinational from the read bank.
// Backpressure: wr_rdy_o drops while the bank being written is still full (both banks busy).
module fft_pingpong_ram #(
  parameter  int DATA_W = 4,
  parameter  int N      = 16,
  localparam int IDX_W  = $clog2(N),
  localparam int WORD_W = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_vld_i,
  input  logic [WORD_W-1:0] wr_dat_i,
  output logic              wr_rdy_o,
  input  logic              rd_first_i,    // present sample 0 of the read bank, clear read index
  input  logic              rd_adv_i,      // present the next sample, advance read index
  input  logic              rd_release_i,  // read bank fully streamed: free it and flip banks
  output logic              rd_full_o,
  output logic [IDX_W-1:0]  rd_idx_o,
  output logic [WORD_W-1:0] rd_dat_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [WORD_W-1:0] mem_q [2][N];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]  rd_addr;
  logic              wr_fire;
  logic              wr_last;

  // Ready comes from registers only, so a release shows up on the next cycle.
  assign wr_rdy_o  = ~full_q[wr_bank_q];
  assign wr_fire   = wr_vld_i & wr_rdy_o;
  assign wr_last   = (wr_idx_q == LAST_IDX);
  assign rd_full_o = full_q[rd_bank_q];
  assign rd_idx_o  = rd_idx_q;

  // Look one sample ahead so the framer's output register holds sample rd_idx.
  assign rd_addr  = rd_first_i ? '0 : rd_idx_q + 1'b1;
  assign rd_dat_o = mem_q[rd_bank_q][rd_addr];

  // Next-state for flags, banks and indices; fill and release never hit the same bank.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    if (wr_fire) begin
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    if (rd_first_i) begin
      rd_idx_d = '0;
    end else if (rd_adv_i) begin
      rd_idx_d = rd_idx_q + 1'b1;
    end
    if (rd_release_i) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // Control state; reset discards any partially written frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  // Sample storage needs no reset: a bank is only read after being fully written.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_idx_q] <= wr_dat_i;
    end
  end

endmodule

// File: rtl/fft_input_framer.sv
// Packs a sample stream into 16-sample frames and replays each one to the FFT core after a 1-cycle core reset.
// Latency: START one cycle after a bank fills (while idle); sample k on the core inputs 1+k cycles after START.
// Backpressure: s_ready low while both banks hold frames; frames launch only after fft_done or the timeout.
module fft_input_framer #(
  parameter int DATA_W         = fft_pkg::DATA_W,
  parameter int N              = fft_pkg::N,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_real,
  input  logic [DATA_W-1:0] s_image,
  output logic              fft_reset,
  output logic [DATA_W-1:0] fft_real,
  output logic [DATA_W-1:0] fft_image,
  input  logic              fft_done,
  output logic [7:0]        frame_count,
  output logic              done_timeout
);

  import fft_pkg::*;

  localparam int                 RD_IDX_W = $clog2(N);
  localparam logic [RD_IDX_W-1:0] RD_LAST = RD_IDX_W'(N - 1);
  localparam int                 TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  fsm_state_t           state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [7:0]           frame_count_q, frame_count_d;
  logic                 done_timeout_q, done_timeout_d;
  logic                 fft_reset_q, fft_reset_d;
  logic [DATA_W-1:0]    fft_real_q, fft_real_d;
  logic [DATA_W-1:0]    fft_image_q, fft_image_d;

  logic                 rd_first, rd_adv, rd_release, rd_full;
  logic [RD_IDX_W-1:0]  rd_idx;
  logic [2*DATA_W-1:0]  rd_dat;

  fft_pingpong_ram #(
    .DATA_W (DATA_W),
    .N      (N)
  ) u_ram (
    .clk          (clk),
    .reset        (reset),
    .wr_vld_i     (s_valid),
    .wr_dat_i     ({s_real, s_image}),
    .wr_rdy_o     (s_ready),
    .rd_first_i   (rd_first),
    .rd_adv_i     (rd_adv),
    .rd_release_i (rd_release),
    .rd_full_o    (rd_full),
    .rd_idx_o     (rd_idx),
    .rd_dat_o     (rd_dat)
  );

  // Sequencer: launch, stream N samples back to back, then wait for done or timeout.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    frame_count_d  = frame_count_q;
    done_timeout_d = done_timeout_q;
    fft_real_d     = fft_real_q;
    fft_image_d    = fft_image_q;
    rd_first       = 1'b0;
    rd_adv         = 1'b0;
    rd_release     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_full) state_d = ST_START;
      end
      ST_START: begin
        rd_first    = 1'b1;
        fft_real_d  = rd_dat[2*DATA_W-1:DATA_W];
        fft_image_d = rd_dat[DATA_W-1:0];
        state_d     = ST_STREAM;
      end
      ST_STREAM: begin
        rd_adv = 1'b1;
        if (rd_idx == RD_LAST) begin
          // Last sample is already in the output register; hold it and free the bank.
          rd_release    = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
          timer_d       = '0;
          state_d       = ST_WAIT_DONE;
        end else begin
          fft_real_d  = rd_dat[2*DATA_W-1:DATA_W];
          fft_image_d = rd_dat[DATA_W-1:0];
        end
      end
      ST_WAIT_DONE: begin
        timer_d = timer_q + 1'b1;
        if (fft_done || (timer_q == TMR_LAST)) begin
          if (!fft_done) done_timeout_d = 1'b1;
          // Pass straight through idle when the other bank is already waiting,
          // so back-to-back frames cost only START + N + the wait.
          state_d = rd_full ? ST_START : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    fft_reset_d = (state_d == ST_START);
  end

  // Registered core-facing outputs; reset holds the core in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      frame_count_q  <= '0;
      done_timeout_q <= 1'b0;
      fft_reset_q    <= 1'b1;
      fft_real_q     <= '0;
      fft_image_q    <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      frame_count_q  <= frame_count_d;
      done_timeout_q <= done_timeout_d;
      fft_reset_q    <= fft_reset_d;
      fft_real_q     <= fft_real_d;
      fft_image_q    <= fft_image_d;
    end
  end

  assign fft_reset    = fft_reset_q;
  assign fft_real     = fft_real_q;
  assign fft_image    = fft_image_q;
  assign frame_count  = frame_count_q;
  assign done_timeout = done_timeout_q;

endmodule
